// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states
// and the alignment rule used when MEM_ACCESS_UNIT_ALIGN_CHECK_EN is defined.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  // True when the access cannot be served: odd half, unaligned word, or size 11.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: extracts and extends load data from a RAM word,
// and merges sub-word store data into the old word.
module mau_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;

  assign byte_sh  = {lane, 3'b000};
  assign half_sh  = {lane[1], 4'b0000};
  assign sel_byte = 8'(word >> byte_sh);
  assign sel_half = 16'(word >> half_sh);

  // Size 11 only reaches here when alignment checking is off, where it acts as a word.
  always_comb begin
    rdata  = word;
    merged = wdata;
    case (size)
      SZ_BYTE: begin
        rdata  = zext ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
        merged = (word & ~(32'hFF << byte_sh)) | ({24'h0, wdata[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        rdata  = zext ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
        merged = (word & ~(32'hFFFF << half_sh)) | ({16'h0, wdata[15:0]} << half_sh);
      end
      default: begin
        rdata  = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit bridging byte/half/word requests onto a zero-latency word RAM.
// Define MEM_ACCESS_UNIT_ALIGN_CHECK_EN to reject misaligned and size-11 accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  state_t state, state_n;

  logic [1:0]        lane_r;
  logic [1:0]        size_r;
  logic              we_r;
  logic              uns_r;
  logic              err_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] word_r;
  logic [ADDR_W-1:0] mem_a_r;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  logic              accept;
  logic              req_err;
  logic              req_sub;
  logic              sub_r;

  assign accept  = req_valid && req_ready;
  assign req_sub = (req_size == SZ_BYTE) || (req_size == SZ_HALF);
  assign sub_r   = (size_r == SZ_BYTE) || (size_r == SZ_HALF);

`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
  assign req_err = misaligned(req_size, req_addr[1:0]);
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_n = RESP;
          else if (!req_we || req_sub) state_n = READ;
          else                         state_n = WRITE;
        end
      end
      READ:    state_n = we_r ? WRITE : RESP;
      WRITE:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The RAM address only moves when an access will actually touch memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lane_r  <= '0;
      size_r  <= '0;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      err_r   <= 1'b0;
      wdata_r <= '0;
      word_r  <= '0;
      mem_a_r <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        lane_r  <= req_addr[1:0];
        size_r  <= req_size;
        we_r    <= req_we;
        uns_r   <= req_unsigned;
        err_r   <= req_err;
        wdata_r <= req_wdata;
        if (!req_err) mem_a_r <= {req_addr[ADDR_W-1:2], 2'b00};
      end
      if (state == READ) word_r <= mem_q;
    end
  end

  mau_lane_align u_lane_align (
    .word   (word_r),
    .lane   (lane_r),
    .size   (size_r),
    .zext   (uns_r),
    .wdata  (wdata_r),
    .rdata  (load_data),
    .merged (merge_data)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (rsp_valid && !we_r && !err_r) ? load_data : '0;
  assign mem_a     = mem_a_r;

`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
  assign rsp_err = rsp_valid && err_r;
`else
  assign rsp_err = 1'b0;
`endif

  // Gating with rst_n keeps a reset during WRITE from reaching the RAM.
  assign mem_we = (state == WRITE) && rst_n;
  assign mem_d  = mem_we ? (sub_r ? merge_data : wdata_r) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a spec-level model predicts each
// response and RAM write; a negedge monitor pops and compares them.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    logic [31:0] a;
    logic [31:0] d;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  logic        ram_ready = 1'b0;
  exp_t        exp_q [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          we_seen = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_a        (mem_a),
    .mem_d        (mem_d),
    .mem_we       (mem_we),
    .mem_q        (mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word RAM attached to the DUT: cleared on the first edge, written on MEM_WE.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_a[11:2]] <= mem_d;
    end
  end

  assign mem_q = ram[mem_a[11:2]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the access rules, independent of any FSM view.
  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] old);
    exp_t        e;
    int          bsh;
    int          hsh;
    logic [31:0] bval;
    logic [31:0] hval;
    logic [1:0]  eff;
    bsh  = 8 * int'(addr[1:0]);
    hsh  = 16 * int'(addr[1]);
    bval = (old >> bsh) & 32'hFF;
    hval = (old >> hsh) & 32'hFFFF;
    if (!uns && bval[7])  bval = bval | 32'hFFFFFF00;
    if (!uns && hval[15]) hval = hval | 32'hFFFF0000;
    eff = (size == 2'b11) ? 2'b10 : size;
    e.err = ALIGN && ((size == 2'b11) || (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00));
    e.a = {addr[31:2], 2'b00};
    e.acc = 0;
    e.rdata = 32'h0;
    e.d = 32'h0;
    e.writes = 0;
    e.lat = 1;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat = 2;
      e.rdata = (eff == 2'b00) ? bval : (eff == 2'b01) ? hval : old;
    end else begin
      e.writes = 1;
      case (eff)
        2'b00: begin
          e.d = (old & ~(32'hFF << bsh)) | ((wdata & 32'hFF) << bsh);
          e.lat = 3;
        end
        2'b01: begin
          e.d = (old & ~(32'hFFFF << hsh)) | ((wdata & 32'hFFFF) << hsh);
          e.lat = 3;
        end
        default: begin
          e.d = wdata;
          e.lat = 2;
        end
      endcase
    end
    return e;
  endfunction

  // Presents one request, waits for acceptance and queues the prediction.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input bit track);
    exp_t e;
    int   budget;
    @(negedge clk);
    budget = 0;
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 32'(req_ready), 32'h1);
      return;
    end
    e = model(we, size, uns, addr, wdata, ref_mem[addr[11:2]]);
    if (track && e.writes != 0) ref_mem[addr[11:2]] = e.d;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_we       = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr     = $urandom;
    req_wdata    = $urandom;
    e.acc = cyc;
    if (track) exp_q.push_back(e);
  endtask

  // Monitor: every write strobe and response is matched against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_mem_we", 32'h1, 32'h0);
      end else begin
        checkOutput("mem_a", mem_a, exp_q[0].a);
        checkOutput("mem_d", mem_d, exp_q[0].d);
      end
      we_seen++;
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_rsp", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        checkOutput("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        checkOutput("write_count", 32'(we_seen), 32'(e.writes));
      end
      we_seen = 0;
    end
  end

  initial begin
    int mism;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

    $display("[TB] reset phase");
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset_mem_a", mem_a, 32'h0);
    checkOutput("reset_mem_d", mem_d, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h8899AABB, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h11223344, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h00ABCDEE, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0302, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b11, 1'b1, 32'h0000_0300, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0303, 32'h12345678, 1'b1);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0000_0301, 32'hCAFEF00D, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000005A, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0FFF, 32'h0, 1'b1);

    $display("[TB] reset during half-store write");
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h00005555, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_req_ready", 32'(req_ready), 32'h1);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 1'b1);

    $display("[TB] random accesses");
    for (int n = 0; n < 200; n++) begin
      a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    a, $urandom, 1'b1);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'h0);
    repeat (2) @(negedge clk);

    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) mism++;
    checkOutput("ram_image_mismatches", 32'(mism), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, byte address width; DATA_W, fixed 32, word width.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous and active-low.
REQ-004 REQ_VALID  input  1  request present.
REQ-005 REQ_READY  output  1  unit can accept a request.
REQ-006 REQ_WE  input  1  1 = store, 0 = load.
REQ-007 REQ_SIZE  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 REQ_UNSIGNED  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 REQ_ADDR  input  ADDR_W  byte address.
REQ-010 REQ_WDATA  input  32  store data, right-justified.
REQ-011 RSP_VALID  output  1  one-cycle completion pulse.
REQ-012 RSP_RDATA  output  32  load result; 0 for stores and errors.
REQ-013 RSP_ERR  output  1  access rejected, with no memory side effect.
REQ-014 MEM_A  output  ADDR_W  byte address to word RAM, bits [1:0] always 00.
REQ-015 MEM_D  output  32  write word.
REQ-016 MEM_WE  output  1  write strobe; the RAM writes MEM_D at the rising edge while it is high.
REQ-017 MEM_Q  input  32  combinational read word at MEM_A, with zero read latency.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WRITE, RESP; REQ_READY=1 only in IDLE.
REQ-019 Acceptance SHALL occur when REQ_VALID&&REQ_READY; all request fields are registered at that edge and are ignored afterwards.
REQ-020 From IDLE, a load or sub-word store SHALL go to READ, a word store to WRITE, and an error to RESP.
REQ-021 In READ, MEM_A SHALL be {addr[ADDR_W-1:2],2'b00} and MEM_Q SHALL be captured; a load then goes to RESP and a sub-word store goes to WRITE.
REQ-022 In WRITE, MEM_WE=1 for exactly one cycle; MEM_D is REQ_WDATA for a word store, or the captured word with the selected byte/half lane replaced for a sub-word store; the next state is RESP.
REQ-023 In RESP, RSP_VALID=1 for one cycle, then IDLE; there is no response back-pressure.
REQ-024 Latency from the acceptance edge to RSP_VALID high SHALL be: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-025 Load extraction SHALL use lane addr[1:0] for a byte and addr[1] for a half, extended to 32 bits per REQ_UNSIGNED.
REQ-026 A store merge SHALL use only the low 8/16 bits of REQ_WDATA; all other bytes of the word keep their old values.
REQ-027 An error SHALL be a half access with addr[0]=1, a word access with addr[1:0]!=0, or REQ_SIZE=11; MEM_WE stays 0 and RSP_RDATA=0.
REQ-028 Outside WRITE, MEM_WE SHALL be 0 and MEM_D SHALL be 0; MEM_A SHALL hold its last value outside READ/WRITE.
REQ-029 A new request SHALL not be accepted in the RESP cycle; back-to-back throughput is at most one request per 3 cycles (load).
REQ-030 The address SHALL wrap modulo 2^ADDR_W with no bounds check.

Reset
REQ-031 While RST_N=0 at an edge, the state SHALL become IDLE with REQ_READY=1 and RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, MEM_WE=0, MEM_A=0, MEM_D=0.
REQ-032 Reset in READ/WRITE/RESP SHALL abort the operation with no response; a write in progress is suppressed if RST_N=0 during that WRITE cycle.

Configuration
REQ-033 Macro MEM_ACCESS_UNIT_ALIGN_CHECK_EN: when defined, REQ-027 applies.
REQ-034 When MEM_ACCESS_UNIT_ALIGN_CHECK_EN is undefined:
- the half lane is selected by addr[1] only;
- a word access ignores addr[1:0];
- size 11 is treated as word;
- RSP_ERR is tied 0 and no request ever errors.

Structure
REQ-035 Package mem_access_unit_pkg SHALL hold the REQ_SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL) and the FSM state encoding.
REQ-036 The combinational sub-module mau_lane_align SHALL perform load extraction/extension and store merge; the FSM and registers stay in mem_access_unit.

Verification
REQ-037 Preload word 0x100 = 0x8899AABB; load byte signed at 0x101 -> RSP_RDATA=0xFFFFFFAA 2 cycles after acceptance, MEM_WE never high.
REQ-038 The same word; load half unsigned at 0x102 -> RSP_RDATA=0x00008899.
REQ-039 Word 0x200 = 0x11223344; store byte 0xEE at 0x203 -> one MEM_WE pulse with MEM_D=0xEE223344, RSP_VALID at +3 cycles, RSP_RDATA=0.
REQ-040 Store word 0xDEADBEEF at 0x300 -> MEM_WE at +1 with MEM_A=0x300, RSP_VALID at +2; a following load word at 0x300 returns 0xDEADBEEF.
REQ-041 With the macro defined, load word at 0x302 -> RSP_ERR=1 at +1, RSP_RDATA=0, no MEM_WE; without the macro -> the word at 0x300 is returned, RSP_ERR=0.
REQ-042 Drop RST_N during the WRITE of a half store -> no MEM_WE pulse, no RSP_VALID, REQ_READY=1 the cycle after reset releases.
